// File: rtl/pingpong_pkg.sv
// Shared types and default sizes for the ping-pong SRAM bank controller.
package pingpong_pkg;

    localparam int PP_DATA_W  = 128;
    localparam int PP_MACRO_W = 64;
    localparam int PP_ADDR_W  = 8;
    localparam int PP_RD_LAT  = 1;

    // Swap controller: IDLE accepts traffic, DRAIN waits for in-flight reads.
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } pp_state_t;

endpackage

// File: rtl/pingpong_rd_pipe.sv
// Read-return tracker: one valid bit and one bank tag per port, delayed by
// RD_LAT stages so the returning SRAM data can be qualified and steered.
module pingpong_rd_pipe #(
    parameter int RD_LAT = 1,
    parameter int PORTS  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] i_valid,
    input  logic [PORTS-1:0] i_tag,
    output logic [PORTS-1:0] o_valid,
    output logic [PORTS-1:0] o_tag,
    output logic             o_empty
);

    logic [PORTS-1:0] r_valid [RD_LAT];
    logic [PORTS-1:0] r_tag   [RD_LAT];
    logic             w_any;

    // Valid bits shift one stage per cycle and are cleared by reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with <= so every stage samples the
        // previous stage's old value; blocking = would collapse the pipe.
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) r_valid[i] <= '0;
        end else begin
            r_valid[0] <= i_valid;
            for (int i = 1; i < RD_LAT; i++) r_valid[i] <= r_valid[i-1];
        end
    end

    // Bank tags follow the valid bits.
    always_ff @(posedge clk) begin
        // NOTE: tags are deliberately not reset; they are only ever used
        // alongside a valid bit, which is reset, so a reset here buys nothing.
        r_tag[0] <= i_tag;
        for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
    end

    // Pipe is empty when no stage of any port holds a read.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        w_any = 1'b0;
        for (int i = 0; i < RD_LAT; i++) w_any = w_any | (|r_valid[i]);
        o_empty = ~w_any;
    end

    assign o_valid = r_valid[RD_LAT-1];
    assign o_tag   = r_tag[RD_LAT-1];

endmodule

// File: rtl/pingpong_mem_ctrl.sv
// Ping-pong controller for two dual-port SRAM banks built from NM macros.
// One bank serves both read ports, the other takes both write ports; a
// swap_req/swap_done handshake exchanges roles after in-flight reads drain.
// Optional macro PINGPONG_COLLIDE_CHK_EN: suppress the port-2 write on a
// same-address dual write and raise a sticky wr_collide flag.
module pingpong_mem_ctrl
    import pingpong_pkg::*;
#(
    parameter int  DATA_W  = PP_DATA_W,
    parameter int  MACRO_W = PP_MACRO_W,
    parameter int  ADDR_W  = PP_ADDR_W,
    parameter int  RD_LAT  = PP_RD_LAT,
    localparam int NM      = DATA_W / MACRO_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rden1,
    input  logic                      rden2,
    input  logic [ADDR_W-1:0]         raddress1,
    input  logic [ADDR_W-1:0]         raddress2,
    output logic                      rvalid1,
    output logic                      rvalid2,
    output logic [DATA_W-1:0]         rdata1,
    output logic [DATA_W-1:0]         rdata2,
    input  logic                      wen1,
    input  logic                      wen2,
    input  logic [ADDR_W-1:0]         waddress1,
    input  logic [ADDR_W-1:0]         waddress2,
    input  logic [DATA_W-1:0]         wdata1,
    input  logic [DATA_W-1:0]         wdata2,
    input  logic                      global_write_enable,
    output logic                      ready,
    input  logic                      swap_req,
    output logic                      swap_busy,
    output logic                      swap_done,
    output logic                      read_bank,
    output logic                      wr_collide,
    output logic                      sram_bist,
    output logic                      sram_awt,
    output logic [2*NM-1:0]           sram_ceba,
    output logic [2*NM-1:0]           sram_cebb,
    output logic [2*NM-1:0]           sram_weba,
    output logic [2*NM-1:0]           sram_webb,
    output logic [2*NM*ADDR_W-1:0]    sram_aa,
    output logic [2*NM*ADDR_W-1:0]    sram_ab,
    output logic [2*NM*MACRO_W-1:0]   sram_da,
    output logic [2*NM*MACRO_W-1:0]   sram_db,
    output logic [2*NM*MACRO_W-1:0]   sram_bweba,
    output logic [2*NM*MACRO_W-1:0]   sram_bwebb,
    input  logic [2*NM*MACRO_W-1:0]   sram_qa,
    input  logic [2*NM*MACRO_W-1:0]   sram_qb
);

    if (DATA_W % MACRO_W != 0) begin : g_bad_width
        $error("DATA_W must be a multiple of MACRO_W");
    end
    if (RD_LAT < 1) begin : g_bad_lat
        $error("RD_LAT must be at least 1");
    end

    pp_state_t   r_state, w_state_nxt;
    logic        r_read_bank, w_read_bank_nxt;
    logic        r_swap_done, w_swap_done_nxt;
    logic        w_ready;
    logic        w_rd_acc1, w_rd_acc2;
    logic        w_wr_req1, w_wr_req2;
    logic        w_wr_acc1, w_wr_acc2;
    logic        w_pipe_empty;
    logic [1:0]  w_pipe_valid, w_pipe_tag;

    assign w_ready   = (r_state == IDLE);
    assign w_rd_acc1 = rden1 & w_ready & ~rst;
    assign w_rd_acc2 = rden2 & w_ready & ~rst;
    assign w_wr_req1 = wen1 & global_write_enable & w_ready & ~rst;
    assign w_wr_req2 = wen2 & global_write_enable & w_ready & ~rst;
    assign w_wr_acc1 = w_wr_req1;

`ifdef PINGPONG_COLLIDE_CHK_EN
    logic w_collide;
    logic r_wr_collide;

    assign w_collide = w_wr_req1 & w_wr_req2 & (waddress1 == waddress2);
    assign w_wr_acc2 = w_wr_req2 & ~w_collide;

    // Sticky collision flag; port 1 wins, only reset clears the flag.
    always_ff @(posedge clk) begin
        if (rst)            r_wr_collide <= 1'b0;
        else if (w_collide) r_wr_collide <= 1'b1;
    end

    assign wr_collide = r_wr_collide;
`else
    assign w_wr_acc2  = w_wr_req2;
    assign wr_collide = 1'b0;
`endif

    // Swap state, bank role and the one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_read_bank <= 1'b0;
            r_swap_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_read_bank <= w_read_bank_nxt;
            r_swap_done <= w_swap_done_nxt;
        end
    end

    // Leave DRAIN only once every read in flight has returned.
    always_comb begin
        w_state_nxt     = r_state;
        w_read_bank_nxt = r_read_bank;
        w_swap_done_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (swap_req) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_pipe_empty) begin
                    w_state_nxt     = IDLE;
                    w_read_bank_nxt = ~r_read_bank;
                    w_swap_done_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    pingpong_rd_pipe #(
        .RD_LAT (RD_LAT),
        .PORTS  (2)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid ({w_rd_acc2, w_rd_acc1}),
        .i_tag   ({r_read_bank, r_read_bank}),
        .o_valid (w_pipe_valid),
        .o_tag   (w_pipe_tag),
        .o_empty (w_pipe_empty)
    );

    // Macro fan-out: the read bank sees read controls, the other bank writes.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam logic BANK_ID = 1'(b);
        logic w_rd_side;
        assign w_rd_side = (r_read_bank == BANK_ID);
        for (genvar m = 0; m < NM; m++) begin : g_macro
            localparam int K = b * NM + m;
            assign sram_ceba[K] = w_rd_side ? ~w_rd_acc1 : ~w_wr_acc1;
            assign sram_cebb[K] = w_rd_side ? ~w_rd_acc2 : ~w_wr_acc2;
            assign sram_weba[K] = w_rd_side ? 1'b1 : ~w_wr_acc1;
            assign sram_webb[K] = w_rd_side ? 1'b1 : ~w_wr_acc2;
            assign sram_aa[K*ADDR_W +: ADDR_W]    = w_rd_side ? raddress1 : waddress1;
            assign sram_ab[K*ADDR_W +: ADDR_W]    = w_rd_side ? raddress2 : waddress2;
            assign sram_da[K*MACRO_W +: MACRO_W]  = wdata1[m*MACRO_W +: MACRO_W];
            assign sram_db[K*MACRO_W +: MACRO_W]  = wdata2[m*MACRO_W +: MACRO_W];
            assign sram_bweba[K*MACRO_W +: MACRO_W] = '0;
            assign sram_bwebb[K*MACRO_W +: MACRO_W] = '0;
        end
    end

    // A bank's macros are contiguous, so its word is one DATA_W slice of q.
    assign rvalid1 = w_pipe_valid[0];
    assign rvalid2 = w_pipe_valid[1];
    assign rdata1  = !w_pipe_valid[0] ? '0 :
                     (w_pipe_tag[0] ? sram_qa[DATA_W +: DATA_W] : sram_qa[0 +: DATA_W]);
    assign rdata2  = !w_pipe_valid[1] ? '0 :
                     (w_pipe_tag[1] ? sram_qb[DATA_W +: DATA_W] : sram_qb[0 +: DATA_W]);

    assign ready     = w_ready;
    assign swap_busy = (r_state == DRAIN);
    assign swap_done = r_swap_done;
    assign read_bank = r_read_bank;
    assign sram_bist = 1'b0;
    assign sram_awt  = 1'b0;

endmodule

// File: tb/tb_pingpong_mem_ctrl.sv
// Directed bench for pingpong_mem_ctrl: a 128-bit (NM=2) and a 256-bit (NM=4)
// instance, both RD_LAT=2, driven in lock-step with behavioural SRAM models.
module tb_pingpong_mem_ctrl;

    localparam int AW = 8;
    localparam int MW = 64;
    localparam int LAT = 2;
`ifdef PINGPONG_COLLIDE_CHK_EN
    localparam logic COL = 1'b1;
`else
    localparam logic COL = 1'b0;
`endif

    logic clk, rst;
    logic rden1, rden2, wen1, wen2, gwe, swap_req;
    logic [AW-1:0]  raddress1, raddress2, waddress1, waddress2;
    logic [255:0]   wdata1, wdata2;

    // 128-bit instance
    logic a_rvalid1, a_rvalid2, a_ready, a_busy, a_done, a_bank, a_col, a_bist, a_awt;
    logic [127:0] a_rdata1, a_rdata2;
    logic [3:0]   a_ceba, a_cebb, a_weba, a_webb;
    logic [31:0]  a_aa, a_ab;
    logic [255:0] a_da, a_db, a_bweba, a_bwebb, a_qa, a_qb;
    // 256-bit instance
    logic b_rvalid1, b_rvalid2, b_ready, b_busy, b_done, b_bank, b_col, b_bist, b_awt;
    logic [255:0] b_rdata1, b_rdata2;
    logic [7:0]   b_ceba, b_cebb, b_weba, b_webb;
    logic [63:0]  b_aa, b_ab;
    logic [511:0] b_da, b_db, b_bweba, b_bwebb, b_qa, b_qb;

    int n_vec = 0;
    int n_fail = 0;

    pingpong_mem_ctrl #(.DATA_W(128), .MACRO_W(MW), .ADDR_W(AW), .RD_LAT(LAT)) u_a (
        .clk(clk), .rst(rst), .rden1(rden1), .rden2(rden2),
        .raddress1(raddress1), .raddress2(raddress2),
        .rvalid1(a_rvalid1), .rvalid2(a_rvalid2), .rdata1(a_rdata1), .rdata2(a_rdata2),
        .wen1(wen1), .wen2(wen2), .waddress1(waddress1), .waddress2(waddress2),
        .wdata1(wdata1[127:0]), .wdata2(wdata2[127:0]), .global_write_enable(gwe),
        .ready(a_ready), .swap_req(swap_req), .swap_busy(a_busy), .swap_done(a_done),
        .read_bank(a_bank), .wr_collide(a_col), .sram_bist(a_bist), .sram_awt(a_awt),
        .sram_ceba(a_ceba), .sram_cebb(a_cebb), .sram_weba(a_weba), .sram_webb(a_webb),
        .sram_aa(a_aa), .sram_ab(a_ab), .sram_da(a_da), .sram_db(a_db),
        .sram_bweba(a_bweba), .sram_bwebb(a_bwebb), .sram_qa(a_qa), .sram_qb(a_qb)
    );

    pingpong_mem_ctrl #(.DATA_W(256), .MACRO_W(MW), .ADDR_W(AW), .RD_LAT(LAT)) u_b (
        .clk(clk), .rst(rst), .rden1(rden1), .rden2(rden2),
        .raddress1(raddress1), .raddress2(raddress2),
        .rvalid1(b_rvalid1), .rvalid2(b_rvalid2), .rdata1(b_rdata1), .rdata2(b_rdata2),
        .wen1(wen1), .wen2(wen2), .waddress1(waddress1), .waddress2(waddress2),
        .wdata1(wdata1), .wdata2(wdata2), .global_write_enable(gwe),
        .ready(b_ready), .swap_req(swap_req), .swap_busy(b_busy), .swap_done(b_done),
        .read_bank(b_bank), .wr_collide(b_col), .sram_bist(b_bist), .sram_awt(b_awt),
        .sram_ceba(b_ceba), .sram_cebb(b_cebb), .sram_weba(b_weba), .sram_webb(b_webb),
        .sram_aa(b_aa), .sram_ab(b_ab), .sram_da(b_da), .sram_db(b_db),
        .sram_bweba(b_bweba), .sram_bwebb(b_bwebb), .sram_qa(b_qa), .sram_qb(b_qb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM model for the 128-bit instance: 4 macros, write/read on the edge,
    // read data delayed to LAT cycles after the access.
    logic [MW-1:0]  a_mem [4][256];
    logic [255:0]   a_qa_s [LAT];
    logic [255:0]   a_qb_s [LAT];
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!a_ceba[k] && !a_weba[k]) a_mem[k][a_aa[k*AW +: AW]] <= a_da[k*MW +: MW];
            if (!a_cebb[k] && !a_webb[k]) a_mem[k][a_ab[k*AW +: AW]] <= a_db[k*MW +: MW];
            if (!a_ceba[k] &&  a_weba[k]) a_qa_s[0][k*MW +: MW] <= a_mem[k][a_aa[k*AW +: AW]];
            if (!a_cebb[k] &&  a_webb[k]) a_qb_s[0][k*MW +: MW] <= a_mem[k][a_ab[k*AW +: AW]];
        end
        a_qa_s[1] <= a_qa_s[0];
        a_qb_s[1] <= a_qb_s[0];
    end
    assign a_qa = a_qa_s[LAT-1];
    assign a_qb = a_qb_s[LAT-1];

    // SRAM model for the 256-bit instance: 8 macros.
    logic [MW-1:0]  b_mem [8][256];
    logic [511:0]   b_qa_s [LAT];
    logic [511:0]   b_qb_s [LAT];
    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (!b_ceba[k] && !b_weba[k]) b_mem[k][b_aa[k*AW +: AW]] <= b_da[k*MW +: MW];
            if (!b_cebb[k] && !b_webb[k]) b_mem[k][b_ab[k*AW +: AW]] <= b_db[k*MW +: MW];
            if (!b_ceba[k] &&  b_weba[k]) b_qa_s[0][k*MW +: MW] <= b_mem[k][b_aa[k*AW +: AW]];
            if (!b_cebb[k] &&  b_webb[k]) b_qb_s[0][k*MW +: MW] <= b_mem[k][b_ab[k*AW +: AW]];
        end
        b_qa_s[1] <= b_qa_s[0];
        b_qb_s[1] <= b_qb_s[0];
    end
    assign b_qa = b_qa_s[LAT-1];
    assign b_qb = b_qb_s[LAT-1];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [255:0] PAT_A5 = {32{8'hA5}};
    localparam logic [255:0] PAT_P  = {64'h1111111111111111, 64'h2222222222222222,
                                       64'h3333333333333333, 64'h4444444444444444};
    localparam logic [255:0] PAT_Q  = {64'hDEAD0000BEEF0003, 64'hDEAD0000BEEF0002,
                                       64'hDEAD0000BEEF0001, 64'hDEAD0000BEEF0000};

    initial begin
        rst = 1'b1; rden1 = 0; rden2 = 0; wen1 = 0; wen2 = 0; gwe = 0; swap_req = 0;
        raddress1 = '0; raddress2 = '0; waddress1 = '0; waddress2 = '0;
        wdata1 = '0; wdata2 = '0;
        tick();

        // Reset held with every request asserted: all chip/write enables high.
        rden1 = 1; rden2 = 1; wen1 = 1; wen2 = 1; gwe = 1;
        #2;
        check("rst_ceba", a_ceba, 4'hF);
        check("rst_weba", a_weba, 4'hF);
        check("rst_cebb", a_cebb, 4'hF);
        check("rst_webb", a_webb, 4'hF);
        check("rst_b_ceb", {b_ceba, b_cebb, b_weba, b_webb}, 32'hFFFF_FFFF);
        check("rst_ready", a_ready, 1'b1);
        check("rst_bank", a_bank, 1'b0);
        check("rst_busy", a_busy, 1'b0);
        check("rst_done", a_done, 1'b0);
        check("rst_rvalid", {a_rvalid1, a_rvalid2}, 2'b00);
        check("rst_rdata1", a_rdata1, 128'h0);
        check("rst_collide", a_col, 1'b0);
        check("rst_tieoffs", {a_bist, a_awt, a_bweba, a_bwebb}, '0);

        // C1: write A5 to addr 3 (port 1) and P to addr 5 (port 2) in bank 1.
        tick();
        rst = 0; rden1 = 0; rden2 = 0; raddress1 = 8'h44;
        wen1 = 1; waddress1 = 8'd3; wdata1 = PAT_A5;
        wen2 = 1; waddress2 = 8'd5; wdata2 = PAT_P;
        #2;
        check("wr_ceba", a_ceba, 4'b0011);
        check("wr_weba", a_weba, 4'b0011);
        check("wr_cebb", a_cebb, 4'b0011);
        check("wr_b_ceba", b_ceba, 8'b0000_1111);
        check("wr_aa_wbank", a_aa[2*AW +: AW], 8'd3);
        check("wr_aa_rbank_follow", a_aa[0 +: AW], 8'h44);
        check("wr_da_slices", a_da[2*MW +: 128], PAT_A5[127:0]);
        check("wr_b_db_slices", b_db[4*MW +: 256], PAT_P);

        // C2: swap request with nothing in flight (t).
        tick();
        wen1 = 0; wen2 = 0; swap_req = 1;
        #2;
        check("swp_t_ready", a_ready, 1'b1);
        check("swp_t_busy", a_busy, 1'b0);

        // C3: t+1, draining.
        tick();
        swap_req = 0;
        #2;
        check("swp_t1_ready", a_ready, 1'b0);
        check("swp_t1_busy", a_busy, 1'b1);
        check("swp_t1_done", a_done, 1'b0);
        check("swp_t1_bank", a_bank, 1'b0);

        // C4: t+2, swap done; read back addr 3 / addr 5 from bank 1.
        tick();
        rden1 = 1; raddress1 = 8'd3; rden2 = 1; raddress2 = 8'd5;
        #2;
        check("swp_t2_done", {a_done, b_done}, 2'b11);
        check("swp_t2_bank", {a_bank, b_bank}, 2'b11);
        check("swp_t2_ready", a_ready, 1'b1);
        check("swp_t2_busy", a_busy, 1'b0);
        check("rd_ceba", a_ceba, 4'b0011);
        check("rd_weba", a_weba, 4'hF);
        check("rd_cebb", a_cebb, 4'b0011);

        // C5: one cycle after the read.
        tick();
        rden1 = 0; rden2 = 0;
        #2;
        check("done_pulse_end", a_done, 1'b0);
        check("rd_lat_early", a_rvalid1, 1'b0);

        // C6: read data arrives RD_LAT cycles after acceptance.
        tick();
        #2;
        check("rd_rvalid", {a_rvalid1, a_rvalid2, b_rvalid1, b_rvalid2}, 4'hF);
        check("rd_rdata1", a_rdata1, PAT_A5[127:0]);
        check("rd_rdata2", a_rdata2, PAT_P[127:0]);
        check("rd_b_rdata1", b_rdata1, PAT_A5);
        check("rd_b_rdata2", b_rdata2, PAT_P);

        // C7: write Q to addr 9 in bank 0.
        tick();
        wen1 = 1; waddress1 = 8'd9; wdata1 = PAT_Q;
        #2;
        check("rd_rvalid_off", a_rvalid1, 1'b0);
        check("rd_rdata_zero", a_rdata1, 128'h0);
        check("wr0_ceba", a_ceba, 4'b1100);

        // C8-C9: swap back to bank 0.
        tick();
        wen1 = 0; swap_req = 1;
        tick();
        swap_req = 0;

        // C10 (t): read addr 9 together with swap_req.
        tick();
        rden1 = 1; raddress1 = 8'd9; swap_req = 1;
        #2;
        check("swp2_done", a_done, 1'b1);
        check("swp2_bank", a_bank, 1'b0);
        check("rdswp_ceba", a_ceba, 4'b1100);

        // C11 (t+1): read held during DRAIN is not accepted.
        tick();
        swap_req = 0;
        #2;
        check("drain_ready", a_ready, 1'b0);
        check("drain_ceba", a_ceba, 4'hF);
        check("drain_rvalid", a_rvalid1, 1'b0);

        // C12 (t+2): the pre-swap read returns from bank 0.
        tick();
        rden1 = 0;
        #2;
        check("rdswp_rvalid", a_rvalid1, 1'b1);
        check("rdswp_rdata", a_rdata1, PAT_Q[127:0]);
        check("rdswp_b_rdata", b_rdata1, PAT_Q);
        check("rdswp_t2_busy", a_busy, 1'b1);
        check("rdswp_t2_done", a_done, 1'b0);

        // C13 (t+3): DRAIN read produced nothing; still draining.
        tick();
        #2;
        check("drain_no_rvalid", a_rvalid1, 1'b0);
        check("rdswp_t3_done", a_done, 1'b0);

        // C14 (t+4): swap completes; write attempt with global enable low.
        tick();
        gwe = 0; wen1 = 1; waddress1 = 8'd9; wdata1 = '0;
        #2;
        check("rdswp_t4_done", {a_done, b_done}, 2'b11);
        check("rdswp_t4_bank", a_bank, 1'b1);
        check("gwe0_ceba", a_ceba, 4'hF);
        check("gwe0_weba", a_weba, 4'hF);

        // C15: both ports write addr 7 with values 1 and 2.
        tick();
        gwe = 1; wen1 = 1; wen2 = 1; waddress1 = 8'd7; waddress2 = 8'd7;
        wdata1 = 256'd1; wdata2 = 256'd2;
        #2;
        check("col_ceba", a_ceba, 4'b1100);
        check("col_cebb", a_cebb, COL ? 4'hF : 4'b1100);
        check("col_webb", a_webb, COL ? 4'hF : 4'b1100);

        // C16: collision flag registered; swap to bank 0.
        tick();
        wen1 = 0; wen2 = 0; swap_req = 1;
        #2;
        check("col_flag", {a_col, b_col}, {COL, COL});
        tick();
        swap_req = 0;

        // C18: read back addr 9 (port 1) and addr 7 (port 2).
        tick();
        rden1 = 1; raddress1 = 8'd9; rden2 = 1; raddress2 = 8'd7;
        #2;
        check("swp3_bank", a_bank, 1'b0);
        tick();
        rden1 = 0; rden2 = 0;
        tick();
        #2;
        check("gwe0_unchanged", a_rdata1, PAT_Q[127:0]);
        check("gwe0_b_unchanged", b_rdata1, PAT_Q);
        check("col_rvalid2", a_rvalid2, 1'b1);
        if (COL) check("col_rdata2", a_rdata2, 128'd1);
        check("col_sticky", a_col, COL);

        // C21-C23: swap to bank 1, then read + swap_req together.
        tick();
        swap_req = 1;
        tick();
        swap_req = 0;
        tick();
        rden1 = 1; raddress1 = 8'd3; swap_req = 1;
        #2;
        check("swp4_bank", a_bank, 1'b1);

        // C24: reset asserted mid-DRAIN.
        tick();
        swap_req = 0; rst = 1;
        #2;
        check("rstdrain_busy", a_busy, 1'b1);
        check("rstdrain_ceba", a_ceba, 4'hF);

        // C25: swap aborted, pipe flushed, flag cleared.
        tick();
        rst = 0; rden1 = 0;
        #2;
        check("abort_bank", {a_bank, b_bank}, 2'b00);
        check("abort_busy", a_busy, 1'b0);
        check("abort_done", a_done, 1'b0);
        check("abort_rvalid", {a_rvalid1, b_rvalid1}, 2'b00);
        check("abort_rdata", a_rdata1, 128'h0);
        check("abort_collide", {a_col, b_col}, 2'b00);
        check("abort_ready", a_ready, 1'b1);
        tick();
        #2;
        check("abort_done_t1", {a_done, b_done}, 2'b00);
        tick();
        #2;
        check("abort_done_t2", {a_done, b_done}, 2'b00);
        check("abort_bank_t2", a_bank, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
